coin_state_ctrl: RTL and testbench
==================================

// Module: coin_state_ctrl
// PURPOSE
//  Per-coin game-logic stage feeding the coin sprite address generator.
//  Owns coin world position, animation frame index, visibility and the collect
//  sequence: spin -> pop upward on player collision -> gone.
//  Emits a one-cycle collect pulse for score/sound logic. Updates once per video frame.
// PARAMETERS
//  X_INIT        400  coin world x at reset/restart (13 b)
//  Y_INIT        120  coin screen y at reset/restart (10 b)
//  FRAMES_PER_IMG  8  video frames per animation step while spinning (>=1)
//  POP_STEP        2  pixels y decreases per video frame during pop
//  POP_HEIGHT     16  total pop rise in pixels; must be a multiple of POP_STEP
//  FRAME_V       240  vcount value at which the frame tick fires
// PORTS
//  pixel_clk_in    in   1   pixel clock
//  rst_in          in   1   asynchronous, active-high reset
//  hcount_in       in  11   raster x
//  vcount_in       in  10   raster y
//  collision_info  in   1   player overlaps this coin (level)
//  reset_signal    in   1   level restart; synchronous; returns coin to spin
//  x_out           out 13   coin world x
//  y_out           out 10   coin screen y
//  image_index_out out  2   animation frame 0..3
//  visible_out     out  1   1 = downstream sprite lookup enabled
//  coin_effect     out  1   one-cycle pulse on collect
//  collected_out   out  1   level, 1 from collect until restart
// BEHAVIOUR
//  frame_tick = (hcount_in==0 && vcount_in==FRAME_V); exactly one cycle per frame.
//  Reset (async): state=SPIN, x_out=X_INIT, y_out=Y_INIT, image_index_out=0,
//   visible_out=1, coin_effect=0, collected_out=0, div_cnt=0, pop_cnt=0.
//  All state updates are on the rising edge of pixel_clk_in; outputs are registered.
//  SPIN: on frame_tick, div_cnt++; when div_cnt==FRAMES_PER_IMG-1, div_cnt<=0 and
//   image_index_out++ (wraps 3->0).
//   If collision_info==1 on any cycle -> POP next edge. coin_effect=1 for exactly that
//   edge's cycle. collected_out<=1, pop_cnt<=0.
//  POP: on each frame_tick:
//   - y_out <= y_out-POP_STEP, clamped at 0 with no wrap.
//   - pop_cnt += POP_STEP.
//   - image_index_out++ every tick (fast spin).
//   When the updated pop_cnt==POP_HEIGHT -> GONE on the same edge.
//   visible_out stays 1 throughout POP.
//  GONE: visible_out=0; x_out, y_out and image_index_out are held.
//   Remain in GONE until reset_signal.
//  collision_info is ignored in POP and GONE, so coin_effect fires at most once per life.
//  reset_signal (any state, highest sync priority): next edge
//   - state=SPIN, outputs restored to their reset values, counters cleared;
//   - collision_info in that same cycle is ignored; no coin_effect.
//  Simultaneous collision_info and frame_tick in SPIN: the transition to POP wins;
//   that tick does not advance div_cnt.
//  x_out is constant in every state; scrolling is applied downstream.
//  Latency: collision_info to coin_effect is 1 cycle. Frame tick to position update
//   is 1 cycle.
// TESTING
//  1 Reset, run 32 frame ticks, no collision -> image_index_out steps 0,1,2,3,0 every
//    8 ticks; y_out=120, visible_out=1.
//  2 Pulse collision_info 1 cycle -> coin_effect high exactly 1 cycle, next edge;
//    collected_out=1; after 8 ticks y_out=104, visible_out=0.
//  3 Hold collision_info high through POP/GONE -> exactly one coin_effect pulse in total.
//  4 Assert reset_signal in mid-POP (y_out=112) -> next cycle y_out=120,
//    image_index_out=0, visible_out=1, collected_out=0.
//  5 Y_INIT=3, collide -> y_out 1,0,0,... with no wrap to 1023; GONE after 8 ticks.
//  6 Assert rst_in asynchronously between clock edges mid-POP -> outputs at reset values
//    immediately, before the next edge.

Source files
------------

// File: rtl/coin_state_ctrl.sv
// rtl/coin_state_ctrl.sv - per-coin spin/pop/gone state, position and collect pulse
module coin_state_ctrl #(
    parameter int X_INIT         = 400,
    parameter int Y_INIT         = 120,
    parameter int FRAMES_PER_IMG = 8,
    parameter int POP_STEP       = 2,
    parameter int POP_HEIGHT     = 16,
    parameter int FRAME_V        = 240
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        collision_info,
    input  logic        reset_signal,
    output logic [12:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  image_index_out,
    output logic        visible_out,
    output logic        coin_effect,
    output logic        collected_out
);

    localparam int DIV_W = (FRAMES_PER_IMG > 1) ? $clog2(FRAMES_PER_IMG) : 1;
    localparam int POP_W = $clog2(POP_HEIGHT + 1);

    typedef enum logic [1:0] {
        SPIN = 2'd0,
        POP  = 2'd1,
        GONE = 2'd2
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [POP_W-1:0]   pop_cnt;
    logic [POP_W-1:0]   pop_next;
    logic               frame_tick;

    assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'(FRAME_V));
    assign pop_next   = pop_cnt + POP_W'(POP_STEP);

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= SPIN;
            x_out           <= 13'(X_INIT);
            y_out           <= 10'(Y_INIT);
            image_index_out <= 2'd0;
            visible_out     <= 1'b1;
            coin_effect     <= 1'b0;
            collected_out   <= 1'b0;
            div_cnt         <= '0;
            pop_cnt         <= '0;
        end else begin
            coin_effect <= 1'b0;
            if (reset_signal) begin
                // Level restart outranks everything, including a same-cycle collision.
                state           <= SPIN;
                x_out           <= 13'(X_INIT);
                y_out           <= 10'(Y_INIT);
                image_index_out <= 2'd0;
                visible_out     <= 1'b1;
                collected_out   <= 1'b0;
                div_cnt         <= '0;
                pop_cnt         <= '0;
            end else begin
                case (state)
                    SPIN: begin
                        if (collision_info) begin
                            state         <= POP;
                            coin_effect   <= 1'b1;
                            collected_out <= 1'b1;
                            pop_cnt       <= '0;
                        end else if (frame_tick) begin
                            if (div_cnt == DIV_W'(FRAMES_PER_IMG - 1)) begin
                                div_cnt         <= '0;
                                image_index_out <= image_index_out + 2'd1;
                            end else begin
                                div_cnt <= div_cnt + DIV_W'(1);
                            end
                        end
                    end
                    POP: begin
                        if (frame_tick) begin
                            // Clamp instead of wrapping to the bottom of the screen.
                            if (y_out < 10'(POP_STEP))
                                y_out <= 10'd0;
                            else
                                y_out <= y_out - 10'(POP_STEP);
                            pop_cnt         <= pop_next;
                            image_index_out <= image_index_out + 2'd1;
                            if (pop_next == POP_W'(POP_HEIGHT)) begin
                                state       <= GONE;
                                visible_out <= 1'b0;
                            end
                        end
                    end
                    GONE: begin
                        visible_out <= 1'b0;
                    end
                    default: begin
                        state <= SPIN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coin_state_ctrl.sv
// tb/tb_coin_state_ctrl.sv - directed self-checking bench for coin_state_ctrl
module tb_coin_state_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        collision;
    logic        restart;
    logic [12:0] x, x2;
    logic [9:0]  y, y2;
    logic [1:0]  idx, idx2;
    logic        vis, vis2, eff, eff2, col, col2;

    int total = 0;
    int bad   = 0;
    int eff_cnt;

    always #5 clk = ~clk;

    coin_state_ctrl dut (
        .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .collision_info(collision), .reset_signal(restart),
        .x_out(x), .y_out(y), .image_index_out(idx), .visible_out(vis),
        .coin_effect(eff), .collected_out(col)
    );

    // Low starting height to exercise the clamp at the top of the screen.
    coin_state_ctrl #(.Y_INIT(3)) dut_low (
        .pixel_clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .collision_info(collision), .reset_signal(restart),
        .x_out(x2), .y_out(y2), .image_index_out(idx2), .visible_out(vis2),
        .coin_effect(eff2), .collected_out(col2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hcount = 11'd0;
        vcount = 10'd240;
        clk1();
        hcount = 11'd5;
    endtask

    task automatic chk_restored(input string tag);
        chk({tag, "_y"}, 32'(y), 120);
        chk({tag, "_idx"}, 32'(idx), 0);
        chk({tag, "_vis"}, 32'(vis), 1);
        chk({tag, "_col"}, 32'(col), 0);
        chk({tag, "_eff"}, 32'(eff), 0);
        chk({tag, "_x"}, 32'(x), 400);
    endtask

    initial begin
        rst = 1'b1; hcount = 11'd5; vcount = 10'd0; collision = 1'b0; restart = 1'b0;
        repeat (3) clk1();
        #2 rst = 1'b0;
        clk1();
        chk_restored("reset");
        chk("reset_y_low", 32'(y2), 3);

        // Free spin: one image step every 8 ticks.
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("spin_idx_%0d", k), 32'(idx), 32'((k / 8) % 4));
        end
        chk("spin_y", 32'(y), 120);
        chk("spin_vis", 32'(vis), 1);
        chk("spin_x", 32'(x), 400);

        // Single-cycle collision: pulse next edge, then pop 16 px over 8 ticks.
        collision = 1'b1;
        clk1();
        chk("collect_eff", 32'(eff), 1);
        chk("collect_col", 32'(col), 1);
        collision = 1'b0;
        clk1();
        chk("collect_eff_drop", 32'(eff), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("pop_y_%0d", k), 32'(y), 32'(120 - 2 * k));
            chk($sformatf("pop_vis_%0d", k), 32'(vis), (k < 8) ? 1 : 0);
            chk($sformatf("pop_ylow_%0d", k), 32'(y2), (k == 1) ? 1 : 0);
            chk($sformatf("pop_vislow_%0d", k), 32'(vis2), (k < 8) ? 1 : 0);
        end
        chk("pop_idx_end", 32'(idx), 0);
        repeat (2) tick();
        chk("gone_y_held", 32'(y), 104);
        chk("gone_idx_held", 32'(idx), 0);
        chk("gone_col", 32'(col), 1);
        chk("gone_ylow", 32'(y2), 0);

        // Restart with collision held: restart cycle ignores collision.
        restart = 1'b1;
        collision = 1'b1;
        clk1();
        chk_restored("restart1");
        restart = 1'b0;
        eff_cnt = 0;
        clk1();
        eff_cnt += int'(eff);
        for (int k = 0; k < 10; k++) begin
            tick();
            eff_cnt += int'(eff);
            clk1();
            eff_cnt += int'(eff);
        end
        chk("held_eff_count", 32'(eff_cnt), 1);
        chk("held_vis", 32'(vis), 0);
        chk("held_y", 32'(y), 104);
        collision = 1'b0;

        // Collision coinciding with a tick that would advance the image.
        restart = 1'b1;
        clk1();
        restart = 1'b0;
        repeat (7) tick();
        chk("pre_coinc_idx", 32'(idx), 0);
        hcount = 11'd0; vcount = 10'd240; collision = 1'b1;
        clk1();
        chk("coinc_eff", 32'(eff), 1);
        chk("coinc_idx", 32'(idx), 0);
        collision = 1'b0; hcount = 11'd5;
        repeat (4) tick();
        chk("midpop_y", 32'(y), 112);
        chk("midpop_vis", 32'(vis), 1);

        // Restart mid-pop, then the divider must start over from zero.
        restart = 1'b1;
        clk1();
        chk_restored("restart2");
        restart = 1'b0;
        repeat (7) tick();
        chk("div_clear_7", 32'(idx), 0);
        tick();
        chk("div_clear_8", 32'(idx), 1);

        // Asynchronous reset between edges during pop.
        collision = 1'b1;
        clk1();
        collision = 1'b0;
        repeat (2) tick();
        chk("async_pre_y", 32'(y), 116);
        #3 rst = 1'b1;
        #1;
        chk_restored("async");
        #2 rst = 1'b0;
        clk1();
        chk("async_after_y", 32'(y), 120);
        chk("async_after_vis", 32'(vis), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
